// File: rtl/des_decrypt_iter_pkg.sv
// Shared DES constants and helpers: permutation tables, decrypt key schedule,
// S-boxes, and the state enum for the iterative decrypt engine.
package des_pkg;

  typedef enum logic {IDLE, RUN} des_state_t;

  // Tables use FIPS 46 numbering: entry value 1 is the MSB of the source word.
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
    12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
    22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Right-rotate amounts; entry 0 belongs to the load cycle, so it is zero.
  localparam int RSHIFT [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam int SBOX [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  function automatic logic [63:0] permIp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
    return y;
  endfunction

  function automatic logic [63:0] permFp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[i])];
    return y;
  endfunction

  function automatic logic [47:0] expandE(input logic [31:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[i])];
    return y;
  endfunction

  function automatic logic [31:0] permP(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[i])];
    return y;
  endfunction

  function automatic logic [55:0] permPc1(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[i])];
    return y;
  endfunction

  function automatic logic [47:0] permPc2(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[i])];
    return y;
  endfunction

  // Row comes from the outer bits of each 6-bit group, column from the inner four.
  function automatic logic [31:0] sboxLayer(input logic [47:0] x);
    logic [31:0] y;
    logic [5:0]  b;
    for (int s = 0; s < 8; s++) begin
      b = x[6'(47 - 6 * s) -: 6];
      y[5'(31 - 4 * s) -: 4] = 4'(SBOX[3'(s)][{b[5], b[0], b[4:1]}]);
    end
    return y;
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    return permP(sboxLayer(expandE(r) ^ k));
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] amt);
    case (amt)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/des_decrypt_iter_if.sv
// Request/result bundle between a block source and the DES decrypt engine.
interface des_decrypt_iter_if;
  logic        start;
  logic [63:0] ciphertext;
  logic [63:0] key;
  logic        busy;
  logic        done;
  logic [63:0] plaintext;

  modport master (output start, ciphertext, key, input busy, done, plaintext);
  modport slave  (input start, ciphertext, key, output busy, done, plaintext);
endinterface

// File: rtl/des_decrypt_iter_round.sv
// One combinational Feistel round: L' = R, R' = L ^ f(R, k).
module des_round
  import des_pkg::*;
(
  input  logic [31:0] l_i,
  input  logic [31:0] r_i,
  input  logic [47:0] k48_i,
  output logic [31:0] l_o,
  output logic [31:0] r_o
);

  assign l_o = r_i;
  assign r_o = l_i ^ feistel(r_i, k48_i);

endmodule

// File: rtl/des_decrypt_iter.sv
// Iterative DES decrypt: loads IP(ciphertext) and PC1(key), runs 16 rounds with
// the right-rotating key schedule, and registers FP of the swapped halves.
module des_decrypt_iter
  import des_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  des_decrypt_iter_if.slave  bus
);

  des_state_t  state_q, state_d;
  logic [3:0]  rnd_q, rnd_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [63:0] pt_q, pt_d;
  logic        done_q, done_d;

  logic [63:0] ipBlock;
  logic [55:0] pc1Key;
  logic [47:0] subKey;
  logic [31:0] roundL, roundR;
  logic [1:0]  shiftAmt;

  assign ipBlock  = permIp(bus.ciphertext);
  assign pc1Key   = permPc1(bus.key);
  assign subKey   = permPc2({c_q, d_q});
  assign shiftAmt = (rnd_q == 4'd15) ? 2'd0 : 2'(RSHIFT[4'(rnd_q + 4'd1)]);

  des_round uRound (
    .l_i   (l_q),
    .r_i   (r_q),
    .k48_i (subKey),
    .l_o   (roundL),
    .r_o   (roundR)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      l_q     <= 32'h0;
      r_q     <= 32'h0;
      c_q     <= 28'h0;
      d_q     <= 28'h0;
      pt_q    <= 64'h0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      l_q     <= l_d;
      r_q     <= r_d;
      c_q     <= c_d;
      d_q     <= d_d;
      pt_q    <= pt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    l_d     = l_q;
    r_d     = r_q;
    c_d     = c_q;
    d_d     = d_q;
    pt_d    = pt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          rnd_d   = 4'd0;
          l_d     = ipBlock[63:32];
          r_d     = ipBlock[31:0];
          c_d     = pc1Key[55:28];
          d_d     = pc1Key[27:0];
        end
      end
      RUN: begin
        l_d = roundL;
        r_d = roundR;
        c_d = rotr28(c_q, shiftAmt);
        d_d = rotr28(d_q, shiftAmt);
        if (rnd_q == 4'd15) begin
          // Last round: the halves are swapped before the final permutation.
          state_d = IDLE;
          rnd_d   = 4'd0;
          pt_d    = permFp({roundR, roundL});
          done_d  = 1'b1;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state_q == RUN);
    bus.done      = done_q;
    bus.plaintext = pt_q;
  end

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Directed bench for des_decrypt_iter using known DES vectors.
module tb_des_decrypt_iter;

  logic clk = 1'b0;
  logic reset;

  des_decrypt_iter_if bus ();

  des_decrypt_iter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // 0: FIPS example, 1: 8787 vector, 2: weak key, 3: same weak key with parity bits cleared.
  logic [63:0] vecKey [4] = '{64'h133457799BBCDFF1, 64'h0E329232EA6D0D73,
                              64'h0101010101010101, 64'h0000000000000000};
  logic [63:0] vecCt  [4] = '{64'h85E813540F0AB405, 64'h0000000000000000,
                              64'h8CA64DE9C1B123A7, 64'h8CA64DE9C1B123A7};
  logic [63:0] vecPt  [4] = '{64'h0123456789ABCDEF, 64'h8787878787878787,
                              64'h0000000000000000, 64'h0000000000000000};

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int v);
    bus.ciphertext = vecCt[v];
    bus.key        = vecKey[v];
  endtask

  // Called at the negedge right after the start edge; lat counts edges after it.
  task automatic waitDone(input bit scribble, output int lat, output int busyCnt, output int overlap);
    lat = -1;
    busyCnt = 0;
    overlap = 0;
    for (int j = 0; j < 40; j++) begin
      if (bus.busy && bus.done) overlap++;
      if (bus.done) begin
        lat = j;
        break;
      end
      if (scribble) begin
        bus.start      = (j % 3 == 1);
        bus.ciphertext = {$urandom, $urandom};
        bus.key        = {$urandom, $urandom};
      end
      if (bus.busy) busyCnt++;
      @(negedge clk);
    end
    if (scribble) bus.start = 1'b0;
  endtask

  task automatic runBlock(input int v, input string tag, input bit scribble);
    int lat, busyCnt, overlap;
    @(negedge clk);
    applyStimulus(v);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    waitDone(scribble, lat, busyCnt, overlap);
    checkOutput({tag, ".latency"}, 64'(lat), 64'd16);
    checkOutput({tag, ".busyCycles"}, 64'(busyCnt), 64'd16);
    checkOutput({tag, ".busyDoneOverlap"}, 64'(overlap), 64'd0);
    checkOutput({tag, ".plaintext"}, bus.plaintext, vecPt[v]);
    @(negedge clk);
    checkOutput({tag, ".donePulse"}, {63'd0, bus.done}, 64'd0);
    checkOutput({tag, ".busyAfter"}, {63'd0, bus.busy}, 64'd0);
    checkOutput({tag, ".plaintextHeld"}, bus.plaintext, vecPt[v]);
  endtask

  initial begin
    int lat, busyCnt, overlap, staleDone;
    reset          = 1'b0;
    bus.start      = 1'b0;
    bus.ciphertext = 64'h0;
    bus.key        = 64'h0;
    repeat (2) @(negedge clk);
    checkOutput("reset.busy", {63'd0, bus.busy}, 64'd0);
    checkOutput("reset.done", {63'd0, bus.done}, 64'd0);
    checkOutput("reset.plaintext", bus.plaintext, 64'h0);
    reset = 1'b1;

    $display("[TB] single blocks");
    runBlock(0, "fips", 1'b0);
    runBlock(1, "vec2", 1'b1);
    runBlock(2, "weakKey", 1'b0);
    runBlock(3, "parityIgnored", 1'b1);

    $display("[TB] back-to-back with start held high");
    @(negedge clk);
    applyStimulus(0);
    bus.start = 1'b1;
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      applyStimulus((b + 1) % 2);
      waitDone(1'b0, lat, busyCnt, overlap);
      checkOutput($sformatf("b2b%0d.period", b), 64'(lat), 64'd16);
      checkOutput($sformatf("b2b%0d.overlap", b), 64'(overlap), 64'd0);
      checkOutput($sformatf("b2b%0d.plaintext", b), bus.plaintext, vecPt[b % 2]);
      if (b == 3) bus.start = 1'b0;
      @(negedge clk);
      if (b < 3) begin
        checkOutput($sformatf("b2b%0d.noBubbleBusy", b), {63'd0, bus.busy}, 64'd1);
        checkOutput($sformatf("b2b%0d.doneFell", b), {63'd0, bus.done}, 64'd0);
      end
    end
    checkOutput("b2b.endBusy", {63'd0, bus.busy}, 64'd0);

    $display("[TB] reset in the middle of a block");
    @(negedge clk);
    applyStimulus(0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("midReset.busyBefore", {63'd0, bus.busy}, 64'd1);
    reset = 1'b0;
    #1;
    checkOutput("midReset.busy", {63'd0, bus.busy}, 64'd0);
    checkOutput("midReset.done", {63'd0, bus.done}, 64'd0);
    checkOutput("midReset.plaintext", bus.plaintext, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    staleDone = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (bus.done || bus.busy) staleDone++;
    end
    checkOutput("midReset.noStaleDone", 64'(staleDone), 64'd0);
    runBlock(1, "afterReset", 1'b0);

    $display("[TB] idle hold");
    for (int j = 0; j < 50; j++) begin
      @(negedge clk);
      checkOutput("idle.plaintext", bus.plaintext, vecPt[1]);
      checkOutput("idle.doneBusy", {62'd0, bus.done, bus.busy}, 64'd0);
    end

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/des_decrypt_iter.md
# des_decrypt_iter

Iterative single-block DES decryption engine: given a 64-bit ciphertext and a 64-bit key, it produces the 64-bit plaintext after 16 round cycles. It is the decrypt-side counterpart of the brute-force key-search datapath. It is used to confirm a candidate key reported by `top` by recovering the known plaintext. It is also a standalone decrypt unit for the FPGA demo.

## Interface
Parameters: none; all DES tables are fixed constants.

- `clk` in 1: single clock, rising-edge.
- `reset` in 1: asynchronous, active-low; asserted (0) clears all state.
- `start` in 1: request; sampled only while idle.
- `ciphertext` in 64: block to decrypt, sampled at the start edge.
- `key` in 64: DES key including parity bits (bits 8,16,…,64 in FIPS numbering are ignored), sampled at the start edge.
- `busy` out 1: engine is running rounds.
- `done` out 1: one-cycle pulse; `plaintext` is valid from this cycle on.
- `plaintext` out 64: result, held until the next result is written or reset.

## Operation
- States:
  - IDLE: reset state.
  - RUN: round counter `rnd` 0..15.
- Reset (`reset`=0, asynchronous):
  - `busy`=0, `done`=0, `plaintext`=64'h0.
  - State IDLE, `rnd`=0.
  - L/R/C/D registers = 0.
- IDLE, `start`=1 at edge N:
  - L‖R ← IP(ciphertext).
  - C‖D ← PC1(key), 28+28 bits.
  - State → RUN, `rnd`=0, `busy`=1 after N.
- RUN, each edge N+1..N+16, with subkey k = PC2(C‖D) evaluated on the current C/D:
  - L' = R and R' = L ^ f(R, k), where f = P(S(E(R) ^ k)).
  - C/D rotate right by `rshift[rnd+1]`, the decrypt schedule. Indexed 0..15 it is 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1, where entry 0 is applied at load, i.e. no shift.
  - This yields subkeys K16, K15, …, K1 in order.
  - `rnd` increments; no wrap occurs inside a block.
- Final round, edge N+16 (`rnd`=15):
  - `plaintext` ← FP(R'‖L'), with the halves swapped.
  - `done`=1 for exactly one cycle.
  - `busy`=0, state → IDLE.
- `start` while `busy`=1: ignored. Inputs may change freely during RUN with no effect.
- `start`=1 in the cycle `done`=1: accepted at the next edge (back-to-back, no bubble). `done` falls on that edge and `busy` rises.
- Reset asserted mid-block: the block is abandoned, outputs return to reset values immediately, and no `done` is produced.
- Plaintext is not corrected for parity; the output is the raw 64-bit result.

## Timing
- Latency: `start` sampled at edge N → `done`=1 and `plaintext` valid in the cycle after edge N+16.
- This gives 17 cycles start-to-done and a throughput of one block per 17 cycles.
- `busy` is high in the cycles after edges N..N+15 (16 cycles).
- `busy` and `done` are never high simultaneously.
- Critical path: one round (E, XOR, S-box, P, XOR) plus PC2, with registered outputs only.

## Structure
- `des_pkg` holds:
  - the permutation tables IP, FP, E, P, PC1, PC2;
  - the decrypt shift schedule;
  - the 8 S-box tables;
  - permutation and S-box helper functions;
  - the state enum `des_state_t` {IDLE, RUN}.
- Sub-module `des_round` is purely combinational: inputs L, R, k48; outputs L', R'.
- The top-level module holds the FSM, the C/D key register and the output register.

## Test plan
- FIPS vector: key 133457799BBCDFF1, ciphertext 85E813540F0AB405, pulse `start` → `done` exactly 17 cycles later with `plaintext`=0123456789ABCDEF. `busy` is high for 16 cycles.
- Second vector: key 0E329232EA6D0D73, ciphertext 0000000000000000 → `plaintext`=8787878787878787.
- Weak key plus parity-ignore: key 0101010101010101, ciphertext 8CA64DE9C1B123A7 → 0000000000000000. Repeating with key 0000000000000000 gives the same result.
- Back-to-back blocks:
  - Hold `start` high continuously with the two vectors above alternating → `done` pulses every 17 cycles with correct alternating results.
  - `start` and input changes while busy do not disturb the results.
- Reset mid-block: assert `reset`=0 at round 8 → `busy`, `done` and `plaintext` are 0 immediately. After release, the next `start` produces a correct result and no stale `done` appears.
- Idle hold: after `done`, leave `start`=0 for 50 cycles → `plaintext` is stable, and `done` and `busy` stay 0.
